dmem_ctrl: RTL and testbench

Data-memory access controller in the M stage of the MIPS pipeline. Takes one load or store per instruction from the M-stage registers and issues it on the data bus with a request/response handshake. It stalls the pipeline until the access completes, and holds the result until the pipeline advances. It drops accesses that already carry an exception (alignment or earlier) or that are flushed, and it extracts and extends load data.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/dmem_load_ext.sv | 26 ++
 rtl/dmem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: M-stage access types, data-bus sizes and
// the data-memory controller state encoding.
package cpu_pkg;

  localparam logic [1:0] MT_WORD = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_BYTE = 2'b10;

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    HOLD
  } dmem_state_t;

endpackage

// File: rtl/dmem_load_ext.sv
// Load data extraction: lane select from the raw bus word and
// sign/zero extension for byte and half loads.
module dmem_load_ext
  import cpu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  m_type,
  input  logic        m_unsigned,
  output logic [31:0] rdata
);

  logic [31:0] sh;

  always_comb begin
    sh = raw >> {addr_lo, 3'b000};
    case (m_type)
      MT_BYTE: rdata = m_unsigned ? {24'd0, sh[7:0]}
                                  : {{24{sh[7]}}, sh[7:0]};
      MT_HALF: rdata = m_unsigned ? {16'd0, sh[15:0]}
                                  : {{16{sh[15]}}, sh[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller with request/response bus handshake.
// Optional counters enabled by defining DMEM_CTRL_STAT_EN.
module dmem_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [1:0]  m_type,
  input  logic        m_unsigned,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_exc,
  input  logic        m_advance,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        stall,
  output logic [31:0] rdata
`ifdef DMEM_CTRL_STAT_EN
  ,
  output logic [31:0] stat_access_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);

  dmem_state_t state_q, state_d;
  logic        abort_q, abort_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  type_q, type_d;
  logic        uns_q, uns_d;
  logic        read_q, read_d;

  logic        trigger;
  logic        done;
  logic        abort_now;
  logic [31:0] ext_data;

  assign trigger = m_valid & (m_read | m_write)
                 & ~m_exc & ~flush;

  dmem_load_ext u_ext (
    .raw        (dresp_data),
    .addr_lo    (addr_q[1:0]),
    .m_type     (type_q),
    .m_unsigned (uns_q),
    .rdata      (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      strobe_q <= '0;
      size_q   <= '0;
      type_q   <= '0;
      uns_q    <= 1'b0;
      read_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      abort_q  <= abort_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      size_q   <= size_d;
      type_q   <= type_d;
      uns_q    <= uns_d;
      read_q   <= read_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    abort_d   = abort_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    strobe_d  = strobe_q;
    size_d    = size_q;
    type_d    = type_q;
    uns_d     = uns_q;
    read_d    = read_q;
    done      = 1'b0;
    abort_now = abort_q | flush;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = ADDR;
          abort_d = 1'b0;
          addr_d  = m_addr;
          type_d  = m_type;
          uns_d   = m_unsigned;
          read_d  = m_read;
          case (m_type)
            MT_BYTE: begin
              size_d   = MSIZE1;
              strobe_d = 4'b0001 << m_addr[1:0];
              wdata_d  = {4{m_wdata[7:0]}};
            end
            MT_HALF: begin
              size_d   = MSIZE2;
              strobe_d = 4'b0011 << {m_addr[1], 1'b0};
              wdata_d  = {2{m_wdata[15:0]}};
            end
            default: begin
              size_d   = MSIZE4;
              strobe_d = 4'b1111;
              wdata_d  = m_wdata;
            end
          endcase
          if (m_read) strobe_d = 4'b0000;
        end
      end
      ADDR: begin
        abort_d = abort_now;
        if (dresp_addr_ok & dresp_data_ok) done = 1'b1;
        else if (dresp_addr_ok) state_d = DATA;
      end
      DATA: begin
        abort_d = abort_now;
        if (dresp_data_ok) done = 1'b1;
      end
      HOLD: begin
        if (m_advance | flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // an aborted access still finishes on the bus, then vanishes
    if (done) begin
      state_d = abort_now ? IDLE : HOLD;
      abort_d = 1'b0;
      if (~abort_now & read_q) rdata_d = ext_data;
    end
  end

  always_comb begin
    dreq_valid  = (state_q == ADDR);
    dreq_addr   = addr_q;
    dreq_size   = size_q;
    dreq_strobe = strobe_q;
    dreq_data   = wdata_q;
    rdata       = rdata_q;
    stall       = (state_q == ADDR) | (state_q == DATA)
                | ((state_q == IDLE) & trigger);
  end

`ifdef DMEM_CTRL_STAT_EN
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic [31:0] stl_cnt_q, stl_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q + {31'd0, done & ~abort_now};
    stl_cnt_d = stl_cnt_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign stat_access_cnt = acc_cnt_q;
  assign stat_stall_cnt  = stl_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed loads/stores, bus delays,
// exceptions, flush/abort, HOLD behaviour and mid-transaction reset.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_read, m_write, m_unsigned;
  logic [1:0]  m_type;
  logic [31:0] m_addr, m_wdata;
  logic        m_exc, m_advance, flush;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        stall;
  logic [31:0] rdata;
`ifdef DMEM_CTRL_STAT_EN
  logic [31:0] stat_access_cnt, stat_stall_cnt;
`endif

  dmem_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .m_valid       (m_valid),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_type        (m_type),
    .m_unsigned    (m_unsigned),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_exc         (m_exc),
    .m_advance     (m_advance),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .stall         (stall),
    .rdata         (rdata)
`ifdef DMEM_CTRL_STAT_EN
    ,
    .stat_access_cnt (stat_access_cnt),
    .stat_stall_cnt  (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic        rd,
                           input logic [1:0]  ty,
                           input logic        uns,
                           input logic [31:0] addr,
                           input logic [31:0] wd,
                           input int          a_dly,
                           input int          d_dly,
                           input logic [31:0] resp,
                           input logic [3:0]  e_strb,
                           input logic [2:0]  e_size,
                           input logic [31:0] e_data,
                           input logic [31:0] e_rdata);
    m_valid = 1'b1; m_read = rd; m_write = ~rd;
    m_type = ty; m_unsigned = uns; m_addr = addr; m_wdata = wd;
    m_exc = 1'b0; flush = 1'b0; m_advance = 1'b0;
    if (rd) exp_q.push_back(e_rdata);
    #1;
    check("trig_stall", {31'd0, stall}, 32'd1);
    check("trig_noreq", {31'd0, dreq_valid}, 32'd0);
    for (int i = 0; i <= a_dly; i++) begin
      tick();
      dresp_addr_ok = (i == a_dly);
      dresp_data_ok = (i == a_dly) && (d_dly == 0);
      dresp_data    = dresp_data_ok ? resp : $urandom;
      #1;
      check("req_valid", {31'd0, dreq_valid}, 32'd1);
      check("req_addr", dreq_addr, addr);
      check("req_size", {29'd0, dreq_size}, {29'd0, e_size});
      check("req_strobe", {28'd0, dreq_strobe}, {28'd0, e_strb});
      if (!rd) check("req_data", dreq_data, e_data);
      check("req_stall", {31'd0, stall}, 32'd1);
    end
    for (int i = 1; i <= d_dly; i++) begin
      tick();
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (i == d_dly);
      dresp_data    = dresp_data_ok ? resp : $urandom;
      #1;
      check("data_noreq", {31'd0, dreq_valid}, 32'd0);
      check("data_stall", {31'd0, stall}, 32'd1);
    end
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    #1;
    check("hold_stall", {31'd0, stall}, 32'd0);
    check("hold_noreq", {31'd0, dreq_valid}, 32'd0);
    if (rd) begin
      last_rdata = exp_q.pop_front();
      check("rdata", rdata, last_rdata);
    end
  endtask

  task automatic hold_wait(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("hw_stall", {31'd0, stall}, 32'd0);
      check("hw_noreq", {31'd0, dreq_valid}, 32'd0);
      check("hw_rdata", rdata, last_rdata);
    end
  endtask

  task automatic advance;
    m_advance = 1'b1;
    tick();
    m_advance = 1'b0;
    m_valid = 1'b0; m_read = 1'b0; m_write = 1'b0;
    #1;
    check("adv_stall", {31'd0, stall}, 32'd0);
    check("adv_noreq", {31'd0, dreq_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_valid = 0; m_read = 0; m_write = 0; m_type = 0;
    m_unsigned = 0; m_addr = 0; m_wdata = 0; m_exc = 0;
    m_advance = 0; flush = 0;
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
    last_rdata = 32'd0;
    tick(); tick();
    check("rst_valid", {31'd0, dreq_valid}, 32'd0);
    check("rst_addr", dreq_addr, 32'd0);
    check("rst_size", {29'd0, dreq_size}, 32'd0);
    check("rst_strobe", {28'd0, dreq_strobe}, 32'd0);
    check("rst_data", dreq_data, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    reset = 1'b0;

    do_access(1, 2'b00, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF,
              4'b0000, 3'd2, 0, 32'hDEADBEEF);
    hold_wait(5);
    advance();

    do_access(0, 2'b10, 0, 32'h203, 32'h5A, 3, 0, 0,
              4'b1000, 3'd0, 32'h5A5A5A5A, 0);
    advance();

    do_access(1, 2'b10, 0, 32'h102, 0, 1, 2, 32'h00800000,
              4'b0000, 3'd0, 0, 32'hFFFFFF80);
    m_advance = 1'b1;
    tick();
    do_access(1, 2'b10, 1, 32'h102, 0, 0, 1, 32'h00800000,
              4'b0000, 3'd0, 0, 32'h00000080);
    advance();

    do_access(1, 2'b01, 0, 32'h102, 0, 0, 0, 32'h80010000,
              4'b0000, 3'd1, 0, 32'hFFFF8001);
    advance();

    do_access(0, 2'b01, 0, 32'h206, 32'hBEEF1234, 2, 0, 0,
              4'b1100, 3'd1, 32'h12341234, 0);
    advance();

    do_access(0, 2'b00, 0, 32'h300, 32'hCAFEF00D, 0, 1, 0,
              4'b1111, 3'd2, 32'hCAFEF00D, 0);
    advance();

    do_access(1, 2'b01, 1, 32'h100, 0, 1, 0, 32'h1234ABCD,
              4'b0000, 3'd1, 0, 32'h0000ABCD);
    advance();

    // faulted and flushed instructions never reach the bus
    m_valid = 1; m_read = 1; m_write = 0; m_exc = 1;
    #1;
    check("exc_stall", {31'd0, stall}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("exc_noreq", {31'd0, dreq_valid}, 32'd0);
      check("exc_stall2", {31'd0, stall}, 32'd0);
    end
    m_exc = 0; flush = 1;
    #1;
    check("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    check("fl_noreq", {31'd0, dreq_valid}, 32'd0);
    m_valid = 0; m_read = 0; flush = 0;

    // flush while waiting for data
    m_valid = 1; m_read = 1; m_type = 2'b00; m_addr = 32'h400;
    #1;
    check("ab_trig", {31'd0, stall}, 32'd1);
    tick();
    dresp_addr_ok = 1;
    #1;
    check("ab_req", {31'd0, dreq_valid}, 32'd1);
    tick();
    dresp_addr_ok = 0; flush = 1; m_valid = 0;
    #1;
    check("ab_data_stall", {31'd0, stall}, 32'd1);
    check("ab_data_noreq", {31'd0, dreq_valid}, 32'd0);
    tick();
    flush = 0;
    #1;
    check("ab_wait_stall", {31'd0, stall}, 32'd1);
    tick();
    dresp_data_ok = 1; dresp_data = 32'h12345678;
    #1;
    check("ab_dok_stall", {31'd0, stall}, 32'd1);
    tick();
    dresp_data_ok = 0;
    #1;
    check("ab_end_stall", {31'd0, stall}, 32'd0);
    check("ab_end_rdata", rdata, last_rdata);
    dresp_data_ok = 1; dresp_data = 32'h55AA55AA;
    tick();
    dresp_data_ok = 0;
    tick();
    check("idle_dok_rdata", rdata, last_rdata);
    check("idle_dok_stall", {31'd0, stall}, 32'd0);

    // flush coinciding with addr_ok
    m_valid = 1; m_read = 1; m_addr = 32'h500;
    tick();
    dresp_addr_ok = 1; flush = 1; m_valid = 0;
    #1;
    check("fa_stall", {31'd0, stall}, 32'd1);
    tick();
    dresp_addr_ok = 0; flush = 0;
    dresp_data_ok = 1; dresp_data = 32'h0BADF00D;
    #1;
    check("fa_data_stall", {31'd0, stall}, 32'd1);
    tick();
    dresp_data_ok = 0;
    #1;
    check("fa_end_stall", {31'd0, stall}, 32'd0);
    check("fa_end_rdata", rdata, last_rdata);

    // flush in HOLD returns to IDLE, next access triggers
    do_access(1, 2'b00, 0, 32'h600, 0, 0, 0, 32'h600D600D,
              4'b0000, 3'd2, 0, 32'h600D600D);
    flush = 1;
    tick();
    flush = 0; m_valid = 0; m_read = 0;
    #1;
    check("hf_stall", {31'd0, stall}, 32'd0);
    do_access(0, 2'b10, 0, 32'h700, 32'hC3, 0, 0, 0,
              4'b0001, 3'd0, 32'hC3C3C3C3, 0);
    advance();

    // reset mid-transaction
    m_valid = 1; m_read = 1; m_write = 0; m_type = 2'b00;
    m_addr = 32'h800;
    tick();
    check("mr_req", {31'd0, dreq_valid}, 32'd1);
    reset = 1; m_valid = 0; m_read = 0;
    tick();
    reset = 0;
    #1;
    check("mr_noreq", {31'd0, dreq_valid}, 32'd0);
    check("mr_stall", {31'd0, stall}, 32'd0);
    check("mr_rdata", rdata, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
